// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply and restoring divide.
// Optional remainder output port enabled by defining ALU_REMAINDER_EN.
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUout,
  output logic             zero,
  output logic             div_by_zero
`ifdef ALU_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   opa;   // multiplicand (MUL) / dividend shifting into quotient (DIV)
  logic [WIDTH-1:0]   opb;   // multiplier (MUL) / divisor (DIV)
  logic [WIDTH-1:0]   acc;
  logic [WIDTH:0]     prem;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [WIDTH:0]     rem_nx;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_nx;
  logic               accept_ok;

  assign accept_ok = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    sc_res = '0;
    shamt  = srcb[SHAMT_W-1:0];
    case (ALUControl)
      OP_ADD:  sc_res = srca + srcb;
      OP_SUB:  sc_res = srca - srcb;
      OP_XOR:  sc_res = srca ^ srcb;
      OP_AND:  sc_res = srca & srcb;
      OP_OR:   sc_res = srca | srcb;
      OP_NOT:  sc_res = ~srca;
      OP_NOR:  sc_res = ~(srca | srcb);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      OP_SLL:  sc_res = srca << shamt;
      OP_SRL:  sc_res = srca >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(srca) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and of restoring divide.
  // prem never exceeds the divisor, so its MSB is always 0 before the shift.
  always_comb begin
    acc_nx   = opb[0] ? (acc + opa) : acc;
    rem_sh   = (prem << 1) | {{WIDTH{1'b0}}, opa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
    q_bit    = (rem_sh >= {1'b0, opb});
    rem_nx   = q_bit ? rem_diff : rem_sh;
    quo_nx   = {opa[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ALUout      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      prem        <= '0;
`ifdef ALU_REMAINDER_EN
      rem         <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept_ok) begin
            opa <= srca;
            opb <= srcb;
            cnt <= '0;
            if (ALUControl == OP_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
              acc   <= '0;
            end else if (ALUControl == OP_DIV && srcb != '0) begin
              state <= S_DIV;
              busy  <= 1'b1;
              prem  <= '0;
            end else if (ALUControl == OP_DIV) begin
              state       <= S_DONE;
              done        <= 1'b1;
              ALUout      <= '1;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
`ifdef ALU_REMAINDER_EN
              rem         <= srca;
`endif
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              ALUout      <= sc_res;
              zero        <= (sc_res == '0);
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          acc <= acc_nx;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            cnt         <= '0;
            ALUout      <= acc_nx;
            zero        <= (acc_nx == '0);
            div_by_zero <= 1'b0;
          end
        end
        S_DIV: begin
          prem <= rem_nx;
          opa  <= quo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            cnt         <= '0;
            ALUout      <= quo_nx;
            zero        <= (quo_nx == '0);
            div_by_zero <= 1'b0;
`ifdef ALU_REMAINDER_EN
            rem         <= rem_nx[WIDTH-1:0];
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu (WIDTH=32); checks rem when ALU_REMAINDER_EN is defined.
module tb_iterative_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, dbz;
  logic [W-1:0] aluout;
`ifdef ALU_REMAINDER_EN
  logic [W-1:0] rem;
`endif

  int checks = 0;
  int failures = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ALUControl(op),
    .srca(a),
    .srcb(b),
    .busy(busy),
    .done(done),
    .ALUout(aluout),
    .zero(zero),
    .div_by_zero(dbz)
`ifdef ALU_REMAINDER_EN
    ,
    .rem(rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t sc_vecs [12] = '{
    '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{4'b1100, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
    '{4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
    '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
    '{4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
    '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0},
    '{4'b0111, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000},
    '{4'b1000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000},
    '{4'b1010, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
    '{4'b1011, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
    '{4'b1100, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000},
    '{4'b1111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge happens inside; returns in cycle N+1 with inputs scrambled.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    op = o; a = x; b = z; start = 1'b1;
    tick();
    start = 1'b0; op = 4'b0000; a = 32'hDEAD_BEEF; b = 32'h0000_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, zero, dbz} !== 4'b0000 || aluout !== '0) begin
      failures++;
      $display("FAIL reset: busy/done/zero/dbz=%b aluout=%h, required 0000 / 00000000",
               {busy, done, zero, dbz}, aluout);
    end
`ifdef ALU_REMAINDER_EN
    checks++;
    if (rem !== '0) begin
      failures++;
      $display("FAIL reset_rem: got %h required 00000000", rem);
    end
`endif
  endtask

  task automatic test_reset_mid_mul();
    int ndone;
    issue(4'b0000, 32'd2, 32'd3);
    checks++;
    if (done !== 1'b1 || aluout !== 32'd5) begin
      failures++;
      $display("FAIL pre_mul_add: done=%b aluout=%h required 1 / 00000005", done, aluout);
    end
    issue(4'b0010, 32'd7, 32'd9);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || aluout !== '0) begin
      failures++;
      $display("FAIL reset_mid_mul: busy/done=%b aluout=%h required 00 / 00000000", {busy, done}, aluout);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0 || aluout !== '0) begin
      failures++;
      $display("FAIL reset_mid_mul_no_done: done pulses=%0d aluout=%h required 0 / 00000000", ndone, aluout);
    end
  endtask

  task automatic test_single_cycle();
    foreach (sc_vecs[i]) begin
      issue(sc_vecs[i].op, sc_vecs[i].a, sc_vecs[i].b);
      checks++;
      if ({busy, done, zero, dbz} !== {2'b01, (sc_vecs[i].y == '0), 1'b0} || aluout !== sc_vecs[i].y) begin
        failures++;
        $display("FAIL single_op%0d: busy/done/zero/dbz=%b aluout=%h required %b / %h", i,
                 {busy, done, zero, dbz}, aluout, {2'b01, (sc_vecs[i].y == '0), 1'b0}, sc_vecs[i].y);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || aluout !== sc_vecs[11].y) begin
      failures++;
      $display("FAIL done_pulse_width: done=%b aluout=%h required 0 / %h", done, aluout, sc_vecs[11].y);
    end
  endtask

  task automatic test_compare();
    issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if (done !== 1'b1 || aluout !== 32'd1 || zero !== 1'b0) begin
      failures++;
      $display("FAIL slt: done=%b aluout=%h zero=%b required 1 / 00000001 / 0", done, aluout, zero);
    end
    issue(4'b1101, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if (done !== 1'b1 || aluout !== 32'd0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sltu: done=%b aluout=%h zero=%b required 1 / 00000000 / 1", done, aluout, zero);
    end
    issue(4'b1101, 32'h0000_0001, 32'hFFFF_FFFF);
    checks++;
    if (done !== 1'b1 || aluout !== 32'd1) begin
      failures++;
      $display("FAIL sltu_true: done=%b aluout=%h required 1 / 00000001", done, aluout);
    end
  endtask

  // Runs a MUL/DIV already issued; checks busy window, held outputs and done at N+33.
  task automatic long_op(input string name, input logic [W-1:0] prev, input logic [W-1:0] exp_y,
                         input bit poke);
    int bad_busy;
    int bad_hold;
    bad_busy = 0;
    bad_hold = 0;
    for (int k = 1; k <= W; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (aluout !== prev) bad_hold++;
      if (poke && k == 5) begin
        op = 4'b0000; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    checks++;
    if (bad_busy != 0 || bad_hold != 0) begin
      failures++;
      $display("FAIL %s_busy_window: cycles without busy=%0d cycles with changed aluout=%0d required 0 / 0",
               name, bad_busy, bad_hold);
    end
    checks++;
    if ({busy, done, zero, dbz} !== {2'b01, (exp_y == '0), 1'b0} || aluout !== exp_y) begin
      failures++;
      $display("FAIL %s_result: busy/done/zero/dbz=%b aluout=%h required %b / %h", name,
               {busy, done, zero, dbz}, aluout, {2'b01, (exp_y == '0), 1'b0}, exp_y);
    end
  endtask

  task automatic test_mul();
    issue(4'b0001, 32'd9, 32'd2);
    issue(4'b0010, 32'h0001_0001, 32'h0001_0001);
    long_op("mul", 32'd7, 32'h0002_0001, 1'b1);
    tick();
    checks++;
    if ({busy, done} !== 2'b00 || aluout !== 32'h0002_0001) begin
      failures++;
      $display("FAIL mul_ignored_start: busy/done=%b aluout=%h required 00 / 00020001", {busy, done}, aluout);
    end
    issue(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    long_op("mul_max", 32'h0002_0001, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_div();
    issue(4'b0011, 32'd100, 32'd7);
    long_op("div", 32'h0000_0001, 32'd14, 1'b0);
`ifdef ALU_REMAINDER_EN
    checks++;
    if (rem !== 32'd2) begin
      failures++;
      $display("FAIL div_rem: got %h required 00000002", rem);
    end
`endif
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0010);
    long_op("div_max", 32'd14, 32'h0FFF_FFFF, 1'b0);
`ifdef ALU_REMAINDER_EN
    checks++;
    if (rem !== 32'h0000_000F) begin
      failures++;
      $display("FAIL div_max_rem: got %h required 0000000f", rem);
    end
`endif
    issue(4'b0011, 32'd5, 32'd0);
    checks++;
    if ({busy, done, zero, dbz} !== 4'b0101 || aluout !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_by_zero: busy/done/zero/dbz=%b aluout=%h required 0101 / ffffffff",
               {busy, done, zero, dbz}, aluout);
    end
`ifdef ALU_REMAINDER_EN
    checks++;
    if (rem !== 32'd5) begin
      failures++;
      $display("FAIL div_by_zero_rem: got %h required 00000005", rem);
    end
`endif
  endtask

  // Entered in the DONE cycle of the divide-by-zero.
  task automatic test_back_to_back();
    op = 4'b0001; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    checks++;
    if ({busy, done, zero, dbz} !== 4'b0110 || aluout !== '0) begin
      failures++;
      $display("FAIL b2b_sub: busy/done/zero/dbz=%b aluout=%h required 0110 / 00000000",
               {busy, done, zero, dbz}, aluout);
    end
    op = 4'b0000; a = 32'd1; b = 32'd1;
    tick();
    checks++;
    if ({busy, done, zero, dbz} !== 4'b0100 || aluout !== 32'd2) begin
      failures++;
      $display("FAIL b2b_add: busy/done/zero/dbz=%b aluout=%h required 0100 / 00000002",
               {busy, done, zero, dbz}, aluout);
    end
    op = 4'b0010; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    long_op("b2b_mul", 32'd2, 32'd15, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_single_cycle();
    test_compare();
    test_mul();
    test_div();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
